// File: rtl/alu_pin_host_if.sv
// Command/response handshake bundle between control logic and the ALU pin host.
// master drives commands and accepts responses; slave is the host itself.
interface alu_pin_host_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_a;
  logic [2:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [5:0] rsp_result;
  logic [5:0] rsp_expected;
  logic       rsp_echo_err;
  logic       rsp_cmp_err;
  logic       rsp_div0;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_expected, rsp_echo_err, rsp_cmp_err, rsp_div0
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_expected, rsp_echo_err, rsp_cmp_err, rsp_div0
  );
endinterface

// File: rtl/alu_pin_host.sv
// Host-side initiator for the 8-pin ALU slice: drives {op, b, a} onto the pins, samples the
// result after a settle delay, checks it against a local recomputation and counts errors.
module alu_pin_host #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  alu_pin_host_if.slave        bus,
  output logic [7:0]           alu_pins_o,
  input  logic [7:0]           alu_pins_i,
  output logic                 alu_rst_o,
  output logic [15:0]          op_count,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {StIdle, StWait, StCapture, StResp} state_e;

  localparam logic [3:0] WaitInit = 4'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [1:0] op_q;
  logic [2:0] a_q;
  logic [2:0] b_q;

  logic [7:0] a8;
  logic [7:0] b8;
  logic [5:0] expected;
  logic       div0;

  // Reference result from the latched command, 8-bit intermediates truncated to 6 bits.
  always_comb begin
    a8       = {5'd0, a_q};
    b8       = {5'd0, b_q};
    div0     = 1'b0;
    expected = '0;
    case (op_q)
      2'b00: expected = 6'(a8 + b8);
      2'b01: expected = 6'(a8 - b8);
      2'b10: expected = 6'(a8 * b8);
      2'b11: begin
        if (b_q == 3'd0) begin
          div0 = 1'b1;
        end else begin
          expected = 6'(a8 / b8);
        end
      end
    endcase
  end

  // Holds the ALU in reset until the first clock edge after rst_n releases.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      alu_rst_o <= 1'b1;
    end else begin
      alu_rst_o <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      op_q             <= '0;
      a_q              <= '0;
      b_q              <= '0;
      alu_pins_o       <= '0;
      bus.cmd_ready    <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_result   <= '0;
      bus.rsp_expected <= '0;
      bus.rsp_echo_err <= 1'b0;
      bus.rsp_cmp_err  <= 1'b0;
      bus.rsp_div0     <= 1'b0;
      op_count         <= '0;
      err_count        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            op_q          <= bus.cmd_op;
            a_q           <= bus.cmd_a;
            b_q           <= bus.cmd_b;
            alu_pins_o    <= {bus.cmd_op, bus.cmd_b, bus.cmd_a};
            cnt_q         <= WaitInit;
            bus.cmd_ready <= 1'b0;
            state_q       <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StCapture;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StCapture: begin
          bus.rsp_result   <= alu_pins_i[5:0];
          bus.rsp_echo_err <= (alu_pins_i[7:6] != op_q);
          bus.rsp_expected <= expected;
          bus.rsp_div0     <= div0;
          bus.rsp_cmp_err  <= !div0 && (alu_pins_i[5:0] != expected);
          bus.rsp_valid    <= 1'b1;
          state_q          <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            op_count      <= op_count + 16'd1;
            if ((bus.rsp_echo_err || bus.rsp_cmp_err) && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
            bus.cmd_ready <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pin_host.sv
// Scoreboard bench for alu_pin_host: stimulus pushes expected responses, a monitor pops and
// compares them on every response handshake against a plain-arithmetic reference.
module tb_alu_pin_host;
  localparam int unsigned Settle = 2;

  logic        CLK;
  logic        rst_n;
  logic [7:0]  alu_pins_o;
  logic [7:0]  alu_pins_i;
  logic        alu_rst_o;
  logic [15:0] op_count;
  logic [7:0]  err_count;

  alu_pin_host_if bus();

  alu_pin_host #(.SETTLE_CYCLES(Settle)) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_pins_o (alu_pins_o),
    .alu_pins_i (alu_pins_i),
    .alu_rst_o  (alu_rst_o),
    .op_count   (op_count),
    .err_count  (err_count)
  );

  typedef struct {
    logic [5:0] res;
    logic [5:0] exp;
    logic       echo;
    logic       cmp;
    logic       div0;
  } rsp_t;

  rsp_t        sb[$];
  rsp_t        mon_e;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned m_ops = 0;
  int unsigned m_errs = 0;
  int unsigned cyc = 0;
  int unsigned hs_cyc = 0;
  int unsigned acc_cyc = 0;
  bit          fault = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int ref_res(input int op, input int a, input int b);
    case (op)
      0:       return (a + b) & 63;
      1:       return (a - b) & 63;
      2:       return (a * b) & 63;
      default: return (b == 0) ? 0 : (a / b) & 63;
    endcase
  endfunction

  // ALU slice model: echoes the opcode and returns the result; division by zero returns all
  // ones. A fault flips the echo LSB and corrupts the result.
  function automatic logic [7:0] alu_model(input logic [7:0] p, input bit f);
    int op, a, b, r;
    logic [1:0] echo;
    logic [5:0] res;
    op   = int'(p[7:6]);
    b    = int'(p[5:3]);
    a    = int'(p[2:0]);
    r    = (op == 3 && b == 0) ? 63 : ref_res(op, a, b);
    echo = p[7:6];
    res  = 6'(r);
    if (f) begin
      echo = echo ^ 2'b01;
      res  = res ^ 6'h15;
    end
    return {echo, res};
  endfunction

  assign alu_pins_i = alu_model(alu_pins_o, fault);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  always @(negedge CLK) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        fail_now("rsp_unexpected");
      end else begin
        mon_e = sb.pop_front();
        check("rsp_result", bus.rsp_result, mon_e.res);
        check("rsp_expected", bus.rsp_expected, mon_e.exp);
        check("rsp_echo_err", bus.rsp_echo_err, mon_e.echo);
        check("rsp_cmp_err", bus.rsp_cmp_err, mon_e.cmp);
        check("rsp_div0", bus.rsp_div0, mon_e.div0);
        check("op_count", op_count, m_ops);
        check("err_count", err_count, m_errs);
        m_ops = (m_ops + 1) & 32'hFFFF;
        if ((mon_e.echo || mon_e.cmp) && m_errs < 255) m_errs++;
      end
      hs_cyc = cyc + 1;
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                      input bit wait_rsp);
    int n;
    rsp_t e;
    logic [7:0] pm;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      fail_now("accept_timeout");
      return;
    end
    pm     = alu_model({op, b, a}, fault);
    e.res  = pm[5:0];
    e.exp  = 6'(ref_res(int'(op), int'(a), int'(b)));
    e.div0 = (op == 2'b11) && (b == 3'd0);
    e.echo = fault;
    e.cmp  = fault && !e.div0;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    bus.cmd_valid = 1'b0;
    acc_cyc = cyc;
    check("pins", alu_pins_o, {op, b, a});
    if (wait_rsp) begin
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
        @(posedge CLK);
        #1;
        n++;
      end
      check("latency", n, Settle + 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_alu_rst", alu_rst_o, 1);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_pins", alu_pins_o, 8'h00);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_err_count", err_count, 0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_alu_rst_held", alu_rst_o, 1);
    rst_n = 1'b1;
    #1;
    check("alu_rst_before_edge", alu_rst_o, 1);
    @(posedge CLK);
    #1;
    check("alu_rst_released", alu_rst_o, 0);

    // Add 5+6
    send(2'b00, 3'd5, 3'd6, 1);
    check("add_result", bus.rsp_result, 11);
    check("add_expected", bus.rsp_expected, 11);
    bus.rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.rsp_ready = 1'b0;
    check("add_op_count", op_count, 1);

    // Back-to-back sub/mul with rsp_ready held high
    bus.rsp_ready = 1'b1;
    send(2'b01, 3'd1, 3'd3, 1);
    check("sub_expected", bus.rsp_expected, 6'h3E);
    send(2'b10, 3'd7, 3'd7, 1);
    check("b2b_gap", acc_cyc, hs_cyc + 1);
    check("mul_expected", bus.rsp_expected, 49);

    // Division, including divide by zero
    send(2'b11, 3'd6, 3'd0, 1);
    check("div0_flag", bus.rsp_div0, 1);
    check("div0_cmp_err", bus.rsp_cmp_err, 0);
    send(2'b11, 3'd7, 3'd2, 1);
    check("div_expected", bus.rsp_expected, 3);
    @(posedge CLK);
    #1;
    check("div_err_count", err_count, 0);

    // Faulty ALU with a 5-cycle response stall; a stray command must be ignored
    bus.rsp_ready = 1'b0;
    fault = 1;
    send(2'b00, 3'd5, 3'd6, 1);
    check("fault_echo_err", bus.rsp_echo_err, 1);
    check("fault_cmp_err", bus.rsp_cmp_err, 1);
    bus.cmd_op    = 2'b10;
    bus.cmd_a     = 3'd3;
    bus.cmd_b     = 3'd4;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      check("stall_valid", bus.rsp_valid, 1);
      check("stall_cmd_ready", bus.cmd_ready, 0);
      check("stall_result", bus.rsp_result, sb[0].res);
      check("stall_expected", bus.rsp_expected, sb[0].exp);
      check("stall_pins", alu_pins_o, 8'h35);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.rsp_ready = 1'b0;
    fault = 0;
    check("fault_err_count", err_count, 1);

    // Randomized operations with random response back-pressure
    for (int i = 0; i < 40; i++) begin
      fault = ($urandom_range(0, 3) == 0);
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
      bus.rsp_ready = 1'b1;
      @(posedge CLK);
      #1;
      bus.rsp_ready = 1'b0;
    end
    fault = 0;

    // Reset while waiting for the ALU to settle
    send(2'b01, 3'd2, 3'd2, 0);
    rst_n = 1'b0;
    #1;
    check("abort_cmd_ready", bus.cmd_ready, 1);
    check("abort_pins", alu_pins_o, 8'h00);
    check("abort_alu_rst", alu_rst_o, 1);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_rsp_result", bus.rsp_result, 0);
    check("abort_op_count", op_count, 0);
    check("abort_err_count", err_count, 0);
    sb.delete();
    m_ops  = 0;
    m_errs = 0;
    repeat (2) @(posedge CLK);
    #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge CLK);
      #1;
      if (bus.rsp_valid) seen++;
    end
    check("abort_no_rsp", seen, 0);

    // Error counter saturation
    fault = 1;
    for (int i = 0; i < 260; i++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1);
    end
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    fault = 0;
    check("sat_err_count", err_count, 255);
    check("sat_op_count", op_count, 260);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
